// File: rtl/wb_commit_unit.sv
// wb_commit_unit: reorder buffer for the way0/way1 writeback results. Entries are
// slotted by their 2-bit program-order ID and retired in order, up to two per cycle.
module wb_commit_unit #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            way0_valid_i,
    output logic            way0_ready_o,
    input  logic            way0_rdWriteEnable_i,
    input  logic [4:0]      way0_rdAddr_i,
    input  logic [XLEN-1:0] way0_rdData_i,
    input  logic [1:0]      way0_pID_i,
    input  logic            way1_valid_i,
    output logic            way1_ready_o,
    input  logic            way1_rdWriteEnable_i,
    input  logic [4:0]      way1_rdAddr_i,
    input  logic [XLEN-1:0] way1_rdData_i,
    input  logic [1:0]      way1_pID_i,
    input  logic            flush_i,
    input  logic [1:0]      flushPID_i,
    output logic            wrEn0_o,
    output logic            wrEn1_o,
    output logic [4:0]      wrAddr0_o,
    output logic [4:0]      wrAddr1_o,
    output logic [XLEN-1:0] wrData0_o,
    output logic [XLEN-1:0] wrData1_o,
    output logic [1:0]      retireCnt_o
);

    logic [DEPTH-1:0] slot_valid_q, slot_valid_d;
    logic [DEPTH-1:0] slot_we_q, slot_we_d;
    logic [4:0]       slot_addr_q [DEPTH];
    logic [4:0]       slot_addr_d [DEPTH];
    logic [XLEN-1:0]  slot_data_q [DEPTH];
    logic [XLEN-1:0]  slot_data_d [DEPTH];
    logic [1:0]       exp_pid_q, exp_pid_d;

    logic             wr_en0_q, wr_en0_d, wr_en1_q, wr_en1_d;
    logic [4:0]       wr_addr0_q, wr_addr0_d, wr_addr1_q, wr_addr1_d;
    logic [XLEN-1:0]  wr_data0_q, wr_data0_d, wr_data1_q, wr_data1_d;
    logic [1:0]       retire_cnt_q, retire_cnt_d;

    logic             ready0_s, ready1_s, acc0_s, acc1_s;
    logic [1:0]       exp_nxt_s;
    logic             ret_a_s, ret_b_s, we0_s, we1_s, waw_s;

    // Handshake: ready looks only at registered occupancy; way0 wins a same-pID collision
    always_comb begin
        ready0_s = ~slot_valid_q[way0_pID_i] & ~flush_i;
        ready1_s = ~slot_valid_q[way1_pID_i] & ~flush_i
                   & ~(way0_valid_i & ready0_s & (way0_pID_i == way1_pID_i));
        acc0_s   = way0_valid_i & ready0_s;
        acc1_s   = way1_valid_i & ready1_s;
    end

    assign way0_ready_o = ready0_s;
    assign way1_ready_o = ready1_s;

    // Retire decision: oldest slot, plus its successor when both are present
    always_comb begin
        exp_nxt_s = exp_pid_q + 2'd1;
        ret_a_s   = slot_valid_q[exp_pid_q] & ~flush_i;
        ret_b_s   = ret_a_s & slot_valid_q[exp_nxt_s];
        we1_s     = ret_b_s & slot_we_q[exp_nxt_s] & (slot_addr_q[exp_nxt_s] != 5'd0);
        waw_s     = we1_s & (slot_addr_q[exp_pid_q] == slot_addr_q[exp_nxt_s]);
        we0_s     = ret_a_s & slot_we_q[exp_pid_q] & (slot_addr_q[exp_pid_q] != 5'd0) & ~waw_s;
    end

    // Next value of the registered register-file write ports
    always_comb begin
        wr_en0_d     = we0_s;
        wr_en1_d     = we1_s;
        wr_addr0_d   = ret_a_s ? slot_addr_q[exp_pid_q] : 5'd0;
        wr_addr1_d   = ret_b_s ? slot_addr_q[exp_nxt_s] : 5'd0;
        wr_data0_d   = ret_a_s ? slot_data_q[exp_pid_q] : {XLEN{1'b0}};
        wr_data1_d   = ret_b_s ? slot_data_q[exp_nxt_s] : {XLEN{1'b0}};
        retire_cnt_d = {ret_b_s, ret_a_s & ~ret_b_s};
    end

    // Slot occupancy/contents and expected pID; accepted and retired slots never coincide
    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_we_d    = slot_we_q;
        slot_addr_d  = slot_addr_q;
        slot_data_d  = slot_data_q;
        if (flush_i) begin
            exp_pid_d = flushPID_i;
        end else begin
            exp_pid_d = exp_pid_q + retire_cnt_d;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (flush_i) begin
                slot_valid_d[i] = 1'b0;
            end else if (acc0_s && (way0_pID_i == 2'(i))) begin
                slot_valid_d[i] = 1'b1;
                slot_we_d[i]    = way0_rdWriteEnable_i;
                slot_addr_d[i]  = way0_rdAddr_i;
                slot_data_d[i]  = way0_rdData_i;
            end else if (acc1_s && (way1_pID_i == 2'(i))) begin
                slot_valid_d[i] = 1'b1;
                slot_we_d[i]    = way1_rdWriteEnable_i;
                slot_addr_d[i]  = way1_rdAddr_i;
                slot_data_d[i]  = way1_rdData_i;
            end else if ((ret_a_s && (exp_pid_q == 2'(i))) || (ret_b_s && (exp_nxt_s == 2'(i)))) begin
                slot_valid_d[i] = 1'b0;
            end else begin
                slot_valid_d[i] = slot_valid_q[i];
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid_q <= {DEPTH{1'b0}};
            slot_we_q    <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                slot_addr_q[i] <= 5'd0;
                slot_data_q[i] <= {XLEN{1'b0}};
            end
            exp_pid_q    <= 2'd0;
            wr_en0_q     <= 1'b0;
            wr_en1_q     <= 1'b0;
            wr_addr0_q   <= 5'd0;
            wr_addr1_q   <= 5'd0;
            wr_data0_q   <= {XLEN{1'b0}};
            wr_data1_q   <= {XLEN{1'b0}};
            retire_cnt_q <= 2'd0;
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_we_q    <= slot_we_d;
            slot_addr_q  <= slot_addr_d;
            slot_data_q  <= slot_data_d;
            exp_pid_q    <= exp_pid_d;
            wr_en0_q     <= wr_en0_d;
            wr_en1_q     <= wr_en1_d;
            wr_addr0_q   <= wr_addr0_d;
            wr_addr1_q   <= wr_addr1_d;
            wr_data0_q   <= wr_data0_d;
            wr_data1_q   <= wr_data1_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign wrEn0_o     = wr_en0_q;
    assign wrEn1_o     = wr_en1_q;
    assign wrAddr0_o   = wr_addr0_q;
    assign wrAddr1_o   = wr_addr1_q;
    assign wrData0_o   = wr_data0_q;
    assign wrData1_o   = wr_data1_q;
    assign retireCnt_o = retire_cnt_q;

endmodule

// File: tb/tb_wb_commit_unit.sv
// Bench for wb_commit_unit: directed vector table for the corner cases, then random
// traffic checked against an in-order retirement model.
module tb_wb_commit_unit;

    localparam int XLEN = 64;
    localparam int NV   = 40;
    localparam int NRND = 2000;

    logic            clk = 1'b0;
    logic            rst, flush_i;
    logic [1:0]      flushPID_i;
    logic            v0, we0, v1, we1;
    logic [4:0]      a0, a1;
    logic [XLEN-1:0] d0, d1;
    logic [1:0]      p0, p1;
    logic            way0_ready_o, way1_ready_o;
    logic            wrEn0_o, wrEn1_o;
    logic [4:0]      wrAddr0_o, wrAddr1_o;
    logic [XLEN-1:0] wrData0_o, wrData1_o;
    logic [1:0]      retireCnt_o;

    always #5 clk = ~clk;

    wb_commit_unit #(.DEPTH(4), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .way0_valid_i(v0), .way0_ready_o(way0_ready_o), .way0_rdWriteEnable_i(we0),
        .way0_rdAddr_i(a0), .way0_rdData_i(d0), .way0_pID_i(p0),
        .way1_valid_i(v1), .way1_ready_o(way1_ready_o), .way1_rdWriteEnable_i(we1),
        .way1_rdAddr_i(a1), .way1_rdData_i(d1), .way1_pID_i(p1),
        .flush_i(flush_i), .flushPID_i(flushPID_i),
        .wrEn0_o(wrEn0_o), .wrEn1_o(wrEn1_o), .wrAddr0_o(wrAddr0_o), .wrAddr1_o(wrAddr1_o),
        .wrData0_o(wrData0_o), .wrData1_o(wrData1_o), .retireCnt_o(retireCnt_o)
    );

    typedef struct {
        logic rst, fl; logic [1:0] fp;
        logic v0, we0; logic [4:0] a0; logic [63:0] d0; logic [1:0] p0;
        logic v1, we1; logic [4:0] a1; logic [63:0] d1; logic [1:0] p1;
        logic chk, r0, r1;
        logic e0, e1; logic [4:0] ea0, ea1; logic [63:0] ed0, ed1; logic [1:0] cnt;
    } vec_t;

    vec_t vecs [NV];
    int   checks = 0;
    int   failures = 0;

    // Reference model: buffered results keyed by pID, retired in order from m_exp
    bit          m_valid [4];
    bit          m_we [4];
    logic [4:0]  m_addr [4];
    logic [63:0] m_data [4];
    int          m_exp;
    bit          m_r0, m_r1, m_e0, m_e1;
    logic [4:0]  m_a0, m_a1;
    logic [63:0] m_d0, m_d1;
    int          m_cnt;

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0h required=%0h", name, idx, act, req);
        end
    endtask

    task automatic model_step();
        int s, t, n;
        m_r0 = !flush_i && !m_valid[p0];
        m_r1 = !flush_i && !m_valid[p1] && !(v0 && m_r0 && (p0 == p1));
        m_e0 = 1'b0; m_e1 = 1'b0; m_a0 = 5'd0; m_a1 = 5'd0; m_d0 = 64'd0; m_d1 = 64'd0; m_cnt = 0;
        if (rst || flush_i) begin
            for (int k = 0; k < 4; k++) m_valid[k] = 1'b0;
            m_exp = rst ? 0 : int'(flushPID_i);
        end else begin
            n = 0;
            while (n < 2 && m_valid[(m_exp + n) % 4]) n++;
            m_cnt = n;
            s = m_exp;
            t = (m_exp + 1) % 4;
            if (n >= 1) begin
                m_e0 = m_we[s] && (m_addr[s] != 5'd0);
                m_a0 = m_addr[s]; m_d0 = m_data[s];
            end
            if (n == 2) begin
                m_e1 = m_we[t] && (m_addr[t] != 5'd0);
                m_a1 = m_addr[t]; m_d1 = m_data[t];
                if (m_e0 && m_e1 && (m_a0 == m_a1)) m_e0 = 1'b0;
            end
            for (int k = 0; k < n; k++) m_valid[(m_exp + k) % 4] = 1'b0;
            m_exp = (m_exp + n) % 4;
            if (v0 && m_r0) begin m_valid[p0] = 1'b1; m_we[p0] = we0; m_addr[p0] = a0; m_data[p0] = d0; end
            if (v1 && m_r1) begin m_valid[p1] = 1'b1; m_we[p1] = we1; m_addr[p1] = a1; m_data[p1] = d1; end
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin m_valid[k] = 1'b0; m_we[k] = 1'b0; m_addr[k] = 5'd0; m_data[k] = 64'd0; end
        m_exp = 0;
        //        rst   fl    fp    | v0  we0  a0     d0      p0    | v1  we1  a1     d1      p1    | chk r0   r1   | e0  e1   ea0    ea1    ed0     ed1     cnt
        vecs[0]  = '{1'b1,1'b0,2'd0, 1'b0,1'b0,5'd0, 64'h0, 2'd0, 1'b0,1'b0,5'd0, 64'h0, 2'd0, 1'b0,1'b0,1'b0, 1'b0,1'b0,5'd0, 5'd0, 64'h0, 64'h0, 2'd0};
        vecs[1]  = '{1'b0,1'b0,2'd0, 1'b0,1'b0,5'd0, 64'h0, 2'd0, 1'b0,1'b0,5'd0, 64'h0, 2'd0, 1'b1,1'b1,1'b1, 1'b0,1'b0,5'd0, 5'd0, 64'h0, 64'h0, 2'd0};
        vecs[2]  = '{1'b0,1'b0,2'd0, 1'b1,1'b1,5'd5, 64'h11,2'd0, 1'b1,1'b1,5'd6, 64'h22,2'd1, 1'b1,1'b1,1'b1, 1'b0,1'b0,5'd0, 5'd0, 64'h0, 64'h0, 2'd0};
        vecs[3]  = '{1'b0,1'b0,2'd0, 1'b0,1'b0,5'd0, 64'h0, 2'd0, 1'b0,1'b0,5'd0, 64'h0, 2'd0, 1'b1,1'b0,1'b0, 1'b1,1'b1,5'd5, 5'd6, 64'h11,64'h22,2'd2};
        vecs[4]  = '{1'b0,1'b0,2'd0, 1'b0,1'b0,5'd0, 64'h0, 2'd0, 1'b0,1'b0,5'd0, 64'h0, 2'd0, 1'b1,1'b1,1'b1, 1'b0,1'b0,5'd0, 5'd0, 64'h0, 64'h0, 2'd0};
        vecs[5]  = '{1'b0,1'b0,2'd0, 1'b0,1'b0,5'd0, 64'h0, 2'd0, 1'b1,1'b1,5'd7, 64'hAA,2'd3, 1'b1,1'b1,1'b1, 1'b0,1'b0,5'd0, 5'd0, 64'h0, 64'h0, 2'd0};
        vecs[6]  = '{1'b0,1'b0,2'd0, 1'b0,1'b0,5'd0, 64'h0, 2'd0, 1'b0,1'b0,5'd0, 64'h0, 2'd0, 1'b1,1'b1,1'b1, 1'b0,1'b0,5'd0, 5'd0, 64'h0, 64'h0, 2'd0};
        vecs[7]  = '{1'b0,1'b0,2'd0, 1'b0,1'b0,5'd0, 64'h0, 2'd0, 1'b0,1'b0,5'd0, 64'h0, 2'd0, 1'b1,1'b1,1'b1, 1'b0,1'b0,5'd0, 5'd0, 64'h0, 64'h0, 2'd0};
        vecs[8]  = '{1'b0,1'b0,2'd0, 1'b1,1'b1,5'd8, 64'hBB,2'd2, 1'b0,1'b0,5'd0, 64'h0, 2'd0, 1'b1,1'b1,1'b1, 1'b0,1'b0,5'd0, 5'd0, 64'h0, 64'h0, 2'd0};
        vecs[9]  = '{1'b0,1'b0,2'd0, 1'b0,1'b0,5'd0, 64'h0, 2'd0, 1'b0,1'b0,5'd0, 64'h0, 2'd0, 1'b1,1'b1,1'b1, 1'b1,1'b1,5'd8, 5'd7, 64'hBB,64'hAA,2'd2};
        vecs[10] = '{1'b0,1'b0,2'd0, 1'b1,1'b1,5'd9, 64'h1, 2'd0, 1'b1,1'b1,5'd9, 64'h2, 2'd1, 1'b1,1'b1,1'b1, 1'b0,1'b0,5'd0, 5'd0, 64'h0, 64'h0, 2'd0};
        vecs[11] = '{1'b0,1'b0,2'd0, 1'b1,1'b1,5'd0, 64'h55,2'd2, 1'b0,1'b0,5'd0, 64'h0, 2'd3, 1'b1,1'b1,1'b1, 1'b0,1'b1,5'd0, 5'd9, 64'h0, 64'h2, 2'd2};
        vecs[12] = '{1'b0,1'b0,2'd0, 1'b0,1'b0,5'd0, 64'h0, 2'd3, 1'b0,1'b0,5'd0, 64'h0, 2'd3, 1'b1,1'b1,1'b1, 1'b0,1'b0,5'd0, 5'd0, 64'h0, 64'h0, 2'd1};
        vecs[13] = '{1'b0,1'b0,2'd0, 1'b0,1'b0,5'd0, 64'h0, 2'd3, 1'b0,1'b0,5'd0, 64'h0, 2'd3, 1'b1,1'b1,1'b1, 1'b0,1'b0,5'd0, 5'd0, 64'h0, 64'h0, 2'd0};
        vecs[14] = '{1'b0,1'b0,2'd0, 1'b1,1'b1,5'd1, 64'h31,2'd3, 1'b1,1'b1,5'd2, 64'h30,2'd0, 1'b1,1'b1,1'b1, 1'b0,1'b0,5'd0, 5'd0, 64'h0, 64'h0, 2'd0};
        vecs[15] = '{1'b0,1'b0,2'd0, 1'b1,1'b1,5'd3, 64'h32,2'd1, 1'b0,1'b0,5'd0, 64'h0, 2'd2, 1'b1,1'b1,1'b1, 1'b1,1'b1,5'd1, 5'd2, 64'h31,64'h30,2'd2};
        vecs[16] = '{1'b0,1'b0,2'd0, 1'b0,1'b0,5'd0, 64'h0, 2'd1, 1'b0,1'b0,5'd0, 64'h0, 2'd2, 1'b1,1'b0,1'b1, 1'b1,1'b0,5'd3, 5'd0, 64'h32,64'h0, 2'd1};
        vecs[17] = '{1'b0,1'b0,2'd0, 1'b1,1'b1,5'd10,64'h40,2'd0, 1'b1,1'b1,5'd11,64'h41,2'd1, 1'b1,1'b1,1'b1, 1'b0,1'b0,5'd0, 5'd0, 64'h0, 64'h0, 2'd0};
        vecs[18] = '{1'b0,1'b0,2'd0, 1'b1,1'b1,5'd12,64'h42,2'd2, 1'b1,1'b1,5'd13,64'h43,2'd3, 1'b1,1'b1,1'b1, 1'b0,1'b0,5'd0, 5'd0, 64'h0, 64'h0, 2'd0};
        vecs[19] = '{1'b0,1'b0,2'd0, 1'b0,1'b0,5'd0, 64'h0, 2'd0, 1'b0,1'b0,5'd0, 64'h0, 2'd2, 1'b1,1'b0,1'b0, 1'b1,1'b1,5'd12,5'd13,64'h42,64'h43,2'd2};
        vecs[20] = '{1'b0,1'b0,2'd0, 1'b0,1'b0,5'd0, 64'h0, 2'd2, 1'b0,1'b0,5'd0, 64'h0, 2'd3, 1'b1,1'b1,1'b1, 1'b1,1'b1,5'd10,5'd11,64'h40,64'h41,2'd2};
        vecs[21] = '{1'b0,1'b0,2'd0, 1'b0,1'b0,5'd0, 64'h0, 2'd0, 1'b0,1'b0,5'd0, 64'h0, 2'd0, 1'b1,1'b1,1'b1, 1'b0,1'b0,5'd0, 5'd0, 64'h0, 64'h0, 2'd0};
        vecs[22] = '{1'b0,1'b0,2'd0, 1'b1,1'b1,5'd14,64'h50,2'd2, 1'b1,1'b1,5'd15,64'h51,2'd2, 1'b1,1'b1,1'b0, 1'b0,1'b0,5'd0, 5'd0, 64'h0, 64'h0, 2'd0};
        vecs[23] = '{1'b0,1'b0,2'd0, 1'b0,1'b0,5'd0, 64'h0, 2'd0, 1'b1,1'b1,5'd15,64'h51,2'd2, 1'b1,1'b1,1'b0, 1'b1,1'b0,5'd14,5'd0, 64'h50,64'h0, 2'd1};
        vecs[24] = '{1'b0,1'b0,2'd0, 1'b0,1'b0,5'd0, 64'h0, 2'd0, 1'b1,1'b1,5'd15,64'h51,2'd2, 1'b1,1'b1,1'b1, 1'b0,1'b0,5'd0, 5'd0, 64'h0, 64'h0, 2'd0};
        vecs[25] = '{1'b0,1'b0,2'd0, 1'b1,1'b1,5'd16,64'h60,2'd3, 1'b1,1'b1,5'd17,64'h61,2'd0, 1'b1,1'b1,1'b1, 1'b0,1'b0,5'd0, 5'd0, 64'h0, 64'h0, 2'd0};
        vecs[26] = '{1'b0,1'b0,2'd0, 1'b1,1'b1,5'd18,64'h62,2'd1, 1'b0,1'b0,5'd0, 64'h0, 2'd3, 1'b1,1'b1,1'b0, 1'b1,1'b1,5'd16,5'd17,64'h60,64'h61,2'd2};
        vecs[27] = '{1'b0,1'b0,2'd0, 1'b0,1'b0,5'd0, 64'h0, 2'd1, 1'b0,1'b0,5'd0, 64'h0, 2'd1, 1'b1,1'b0,1'b0, 1'b1,1'b1,5'd18,5'd15,64'h62,64'h51,2'd2};
        vecs[28] = '{1'b0,1'b0,2'd0, 1'b1,1'b1,5'd20,64'h70,2'd0, 1'b1,1'b1,5'd21,64'h71,2'd1, 1'b1,1'b1,1'b1, 1'b0,1'b0,5'd0, 5'd0, 64'h0, 64'h0, 2'd0};
        vecs[29] = '{1'b0,1'b0,2'd0, 1'b1,1'b1,5'd22,64'h72,2'd2, 1'b0,1'b0,5'd0, 64'h0, 2'd3, 1'b1,1'b1,1'b1, 1'b0,1'b0,5'd0, 5'd0, 64'h0, 64'h0, 2'd0};
        vecs[30] = '{1'b0,1'b1,2'd2, 1'b1,1'b1,5'd23,64'h99,2'd3, 1'b0,1'b0,5'd0, 64'h0, 2'd3, 1'b1,1'b0,1'b0, 1'b0,1'b0,5'd0, 5'd0, 64'h0, 64'h0, 2'd0};
        vecs[31] = '{1'b0,1'b0,2'd0, 1'b0,1'b0,5'd0, 64'h0, 2'd2, 1'b0,1'b0,5'd0, 64'h0, 2'd2, 1'b1,1'b1,1'b1, 1'b0,1'b0,5'd0, 5'd0, 64'h0, 64'h0, 2'd0};
        vecs[32] = '{1'b0,1'b0,2'd0, 1'b1,1'b1,5'd23,64'h80,2'd2, 1'b1,1'b1,5'd24,64'h81,2'd3, 1'b1,1'b1,1'b1, 1'b0,1'b0,5'd0, 5'd0, 64'h0, 64'h0, 2'd0};
        vecs[33] = '{1'b0,1'b0,2'd0, 1'b0,1'b0,5'd0, 64'h0, 2'd0, 1'b0,1'b0,5'd0, 64'h0, 2'd0, 1'b1,1'b1,1'b1, 1'b1,1'b1,5'd23,5'd24,64'h80,64'h81,2'd2};
        vecs[34] = '{1'b0,1'b0,2'd0, 1'b1,1'b1,5'd25,64'h90,2'd1, 1'b1,1'b1,5'd26,64'h91,2'd2, 1'b1,1'b1,1'b1, 1'b0,1'b0,5'd0, 5'd0, 64'h0, 64'h0, 2'd0};
        vecs[35] = '{1'b0,1'b0,2'd0, 1'b1,1'b1,5'd27,64'h92,2'd3, 1'b0,1'b0,5'd0, 64'h0, 2'd0, 1'b1,1'b1,1'b1, 1'b0,1'b0,5'd0, 5'd0, 64'h0, 64'h0, 2'd0};
        vecs[36] = '{1'b1,1'b1,2'd3, 1'b1,1'b1,5'd28,64'hA0,2'd0, 1'b0,1'b0,5'd0, 64'h0, 2'd0, 1'b1,1'b0,1'b0, 1'b0,1'b0,5'd0, 5'd0, 64'h0, 64'h0, 2'd0};
        vecs[37] = '{1'b0,1'b0,2'd0, 1'b0,1'b0,5'd0, 64'h0, 2'd1, 1'b0,1'b0,5'd0, 64'h0, 2'd2, 1'b1,1'b1,1'b1, 1'b0,1'b0,5'd0, 5'd0, 64'h0, 64'h0, 2'd0};
        vecs[38] = '{1'b0,1'b0,2'd0, 1'b1,1'b1,5'd29,64'hB0,2'd0, 1'b1,1'b1,5'd30,64'hB1,2'd1, 1'b1,1'b1,1'b1, 1'b0,1'b0,5'd0, 5'd0, 64'h0, 64'h0, 2'd0};
        vecs[39] = '{1'b0,1'b0,2'd0, 1'b0,1'b0,5'd0, 64'h0, 2'd3, 1'b0,1'b0,5'd0, 64'h0, 2'd3, 1'b1,1'b1,1'b1, 1'b1,1'b1,5'd29,5'd30,64'hB0,64'hB1,2'd2};

        for (int i = 0; i < NV; i++) begin
            rst = vecs[i].rst; flush_i = vecs[i].fl; flushPID_i = vecs[i].fp;
            v0 = vecs[i].v0; we0 = vecs[i].we0; a0 = vecs[i].a0; d0 = vecs[i].d0; p0 = vecs[i].p0;
            v1 = vecs[i].v1; we1 = vecs[i].we1; a1 = vecs[i].a1; d1 = vecs[i].d1; p1 = vecs[i].p1;
            #1;
            model_step();
            if (vecs[i].chk) begin
                chk("vec_ready0", i, 64'(way0_ready_o), 64'(vecs[i].r0));
                chk("vec_ready1", i, 64'(way1_ready_o), 64'(vecs[i].r1));
            end
            @(posedge clk);
            #1;
            chk("vec_wrEn0", i, 64'(wrEn0_o), 64'(vecs[i].e0));
            chk("vec_wrEn1", i, 64'(wrEn1_o), 64'(vecs[i].e1));
            chk("vec_retireCnt", i, 64'(retireCnt_o), 64'(vecs[i].cnt));
            if (vecs[i].e0) begin
                chk("vec_wrAddr0", i, 64'(wrAddr0_o), 64'(vecs[i].ea0));
                chk("vec_wrData0", i, wrData0_o, vecs[i].ed0);
            end
            if (vecs[i].e1) begin
                chk("vec_wrAddr1", i, 64'(wrAddr1_o), 64'(vecs[i].ea1));
                chk("vec_wrData1", i, wrData1_o, vecs[i].ed1);
            end
        end

        for (int i = 0; i < NRND; i++) begin
            rst        = ($urandom_range(0, 199) == 0);
            flush_i    = ($urandom_range(0, 39) == 0);
            flushPID_i = 2'($urandom_range(0, 3));
            v0  = ($urandom_range(0, 3) != 0);
            we0 = ($urandom_range(0, 3) != 0);
            a0  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            d0  = {$urandom, $urandom};
            p0  = 2'($urandom_range(0, 3));
            v1  = ($urandom_range(0, 3) != 0);
            we1 = ($urandom_range(0, 3) != 0);
            a1  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            d1  = {$urandom, $urandom};
            p1  = ($urandom_range(0, 4) == 0) ? p0 : 2'($urandom_range(0, 3));
            #1;
            model_step();
            chk("rnd_ready0", i, 64'(way0_ready_o), 64'(m_r0));
            chk("rnd_ready1", i, 64'(way1_ready_o), 64'(m_r1));
            @(posedge clk);
            #1;
            chk("rnd_wrEn0", i, 64'(wrEn0_o), 64'(m_e0));
            chk("rnd_wrEn1", i, 64'(wrEn1_o), 64'(m_e1));
            chk("rnd_retireCnt", i, 64'(retireCnt_o), 64'(m_cnt));
            if (m_e0) begin
                chk("rnd_wrAddr0", i, 64'(wrAddr0_o), 64'(m_a0));
                chk("rnd_wrData0", i, wrData0_o, m_d0);
            end
            if (m_e1) begin
                chk("rnd_wrAddr1", i, 64'(wrAddr1_o), 64'(m_a1));
                chk("rnd_wrData1", i, wrData1_o, m_d1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
